// File: rtl/run_sequencer_pkg.sv
// Shared types for the run sequencer: ALU op mnemonics, instruction opcodes,
// sequencer states and the decoded strobe bundle.
package definitions;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_XOR  = 3'd4,
        ALU_SHL  = 3'd5,
        ALU_SHR  = 3'd6,
        ALU_PASS = 3'd7
    } op_mne;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_AND = 4'h2, OP_OR   = 4'h3,
        OP_XOR  = 4'h4, OP_SHL  = 4'h5, OP_SHR = 4'h6, OP_ADDI = 4'h7,
        OP_LD   = 4'h8, OP_ST   = 4'h9, OP_BNZ = 4'hA, OP_BZ   = 4'hB,
        OP_JMP  = 4'hC, OP_JR   = 4'hD, OP_SETR = 4'hE, OP_HALT = 4'hF
    } opc_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT   = 3'd1,
        S_RUN    = 3'd2,
        S_DRAIN  = 3'd3,
        S_FINISH = 3'd4
    } seq_state_e;

    typedef struct packed {
        op_mne alu_op;
        logic  branch_rel_nz;
        logic  branch_rel_z;
        logic  branch_abs;
        logic  reg_write_en;
        logic  reg_sel;
        logic  lut_in;
        logic  mem_to_reg;
        logic  alu_src;
        logic  alu_sc_in;
        logic  read_mem;
        logic  write_mem;
    } ctrl_t;

endpackage

// File: rtl/run_sequencer_if.sv
// Host handshake plus datapath opcode/strobe bundle of the run sequencer.
interface run_sequencer_if #(parameter int CW = 16);
    logic          go, abort, busy, host_done, timeout;
    logic [CW-1:0] cycles;
    logic [3:0]    opcode;
    logic          fcode, DONE, START;
    logic          CTRL_branch_rel_nz, CTRL_branch_rel_z, CTRL_branch_abs;
    logic          CTRL_reg_write_en, CTRL_reg_sel, CTRL_lut_in, CTRL_mem_to_reg;
    logic          CTRL_alu_src, CTRL_alu_sc_in, CTRL_read_mem, CTRL_write_mem;
    logic [2:0]    CTRL_alu_op;

    modport master (
        input  go, abort, opcode, fcode, DONE,
        output busy, host_done, timeout, cycles, START,
               CTRL_branch_rel_nz, CTRL_branch_rel_z, CTRL_branch_abs,
               CTRL_reg_write_en, CTRL_reg_sel, CTRL_lut_in, CTRL_mem_to_reg,
               CTRL_alu_src, CTRL_alu_sc_in, CTRL_read_mem, CTRL_write_mem, CTRL_alu_op
    );

    modport slave (
        output go, abort, opcode, fcode, DONE,
        input  busy, host_done, timeout, cycles, START,
               CTRL_branch_rel_nz, CTRL_branch_rel_z, CTRL_branch_abs,
               CTRL_reg_write_en, CTRL_reg_sel, CTRL_lut_in, CTRL_mem_to_reg,
               CTRL_alu_src, CTRL_alu_sc_in, CTRL_read_mem, CTRL_write_mem, CTRL_alu_op
    );
endinterface

// File: rtl/run_sequencer_ctrl_decode.sv
// Combinational opcode/fcode to strobe decode; all strobes low unless enabled.
module ctrl_decode
    import definitions::*;
(
    input  logic [3:0] opcode_i,
    input  logic       fcode_i,
    input  logic       en_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        if (en_i) begin
            case (opc_e'(opcode_i))
                // opcodes 0..6 share their encoding with the ALU op
                OP_ADD, OP_AND, OP_OR, OP_XOR: begin
                    ctrl_o.alu_op       = op_mne'(opcode_i[2:0]);
                    ctrl_o.reg_write_en = 1'b1;
                end
                OP_SUB: begin
                    ctrl_o.alu_op       = ALU_SUB;
                    ctrl_o.reg_write_en = 1'b1;
                    ctrl_o.alu_sc_in    = 1'b1;
                end
                OP_SHL, OP_SHR: begin
                    ctrl_o.alu_op       = op_mne'(opcode_i[2:0]);
                    ctrl_o.reg_write_en = 1'b1;
                    ctrl_o.alu_sc_in    = fcode_i;
                end
                OP_ADDI: begin
                    ctrl_o.alu_op       = ALU_ADD;
                    ctrl_o.alu_src      = 1'b1;
                    ctrl_o.reg_write_en = 1'b1;
                end
                OP_LD: begin
                    ctrl_o.read_mem     = 1'b1;
                    ctrl_o.mem_to_reg   = 1'b1;
                    ctrl_o.reg_write_en = 1'b1;
                end
                OP_ST:   ctrl_o.write_mem     = 1'b1;
                OP_BNZ:  ctrl_o.branch_rel_nz = 1'b1;
                OP_BZ:   ctrl_o.branch_rel_z  = 1'b1;
                OP_JMP:  ctrl_o.branch_abs    = 1'b1;
                OP_JR: begin
                    ctrl_o.branch_abs = 1'b1;
                    ctrl_o.lut_in     = 1'b1;
                end
                OP_SETR: begin
                    ctrl_o.reg_sel      = 1'b1;
                    ctrl_o.reg_write_en = 1'b1;
                end
                OP_HALT: ctrl_o.alu_op = ALU_PASS;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/run_sequencer.sv
// Run controller: go/done host handshake, datapath init hold, RUN-cycle
// counting with watchdog, and a one-cycle drain before reporting done.
module run_sequencer
    import definitions::*;
#(
    parameter int          CW          = 16,
    parameter int unsigned MAX_CYCLES  = 32'hFFFF,
    parameter int          INIT_CYCLES = 2
) (
    input  logic             CLK,
    input  logic             reset,
    run_sequencer_if.master  bus
);

    localparam int          IW        = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [IW-1:0] INIT_LOAD = IW'(INIT_CYCLES - 1);
    localparam logic [CW-1:0] LIMIT     = CW'(MAX_CYCLES - 1);

    seq_state_e    state_q, state_d;
    logic [IW-1:0] icnt_q, icnt_d;
    logic [CW-1:0] cycles_q, cycles_d;
    logic          timeout_q, timeout_d;
    ctrl_t         ctrl;

    always_comb begin
        state_d   = state_q;
        icnt_d    = icnt_q;
        cycles_d  = cycles_q;
        timeout_d = timeout_q;
        case (state_q)
            S_IDLE: if (bus.go) begin
                state_d   = S_INIT;
                icnt_d    = INIT_LOAD;
                cycles_d  = '0;
                timeout_d = 1'b0;
            end
            S_INIT: begin
                if (bus.abort)         state_d = S_IDLE;
                else if (icnt_q == '0) state_d = S_RUN;
                else                   icnt_d  = icnt_q - IW'(1);
            end
            S_RUN: begin
                // the aborting or DONE-seeing cycle still executed, so it counts
                if (cycles_q != '1) cycles_d = cycles_q + CW'(1);
                if (bus.abort)     state_d = S_IDLE;
                else if (bus.DONE) state_d = S_DRAIN;
                else if (cycles_q == LIMIT) begin
                    state_d   = S_FINISH;
                    timeout_d = 1'b1;
                end
            end
            S_DRAIN:  state_d = S_FINISH;
            S_FINISH: if (!bus.go) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            icnt_q    <= '0;
            cycles_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            icnt_q    <= icnt_d;
            cycles_q  <= cycles_d;
            timeout_q <= timeout_d;
        end
    end

    ctrl_decode u_dec (
        .opcode_i (bus.opcode),
        .fcode_i  (bus.fcode),
        .en_i     (state_q == S_RUN),
        .ctrl_o   (ctrl)
    );

    assign bus.START     = (state_q != S_RUN) && (state_q != S_DRAIN);
    assign bus.busy      = (state_q == S_INIT) || (state_q == S_RUN) || (state_q == S_DRAIN);
    assign bus.host_done = (state_q == S_FINISH);
    assign bus.timeout   = timeout_q;
    assign bus.cycles    = cycles_q;

    assign bus.CTRL_alu_op        = ctrl.alu_op;
    assign bus.CTRL_branch_rel_nz = ctrl.branch_rel_nz;
    assign bus.CTRL_branch_rel_z  = ctrl.branch_rel_z;
    assign bus.CTRL_branch_abs    = ctrl.branch_abs;
    assign bus.CTRL_reg_write_en  = ctrl.reg_write_en;
    assign bus.CTRL_reg_sel       = ctrl.reg_sel;
    assign bus.CTRL_lut_in        = ctrl.lut_in;
    assign bus.CTRL_mem_to_reg    = ctrl.mem_to_reg;
    assign bus.CTRL_alu_src       = ctrl.alu_src;
    assign bus.CTRL_alu_sc_in     = ctrl.alu_sc_in;
    assign bus.CTRL_read_mem      = ctrl.read_mem;
    assign bus.CTRL_write_mem     = ctrl.write_mem;

endmodule

// File: tb/tb_run_sequencer.sv
// Scoreboard bench: dut 0 uses the default watchdog, dut 1 has MAX_CYCLES=5.
module tb_run_sequencer;

    logic CLK = 1'b0;
    logic reset;
    always #5 CLK = ~CLK;

    logic       go_v [2];
    logic       ab_v [2];
    logic [3:0] op_v [2];
    logic       fc_v [2];
    logic       dn_v [2];

    run_sequencer_if #(.CW(16)) ifa ();
    run_sequencer_if #(.CW(16)) ifb ();

    assign ifa.go = go_v[0]; assign ifa.abort = ab_v[0]; assign ifa.opcode = op_v[0];
    assign ifa.fcode = fc_v[0]; assign ifa.DONE = dn_v[0];
    assign ifb.go = go_v[1]; assign ifb.abort = ab_v[1]; assign ifb.opcode = op_v[1];
    assign ifb.fcode = fc_v[1]; assign ifb.DONE = dn_v[1];

    run_sequencer #(.CW(16), .MAX_CYCLES(32'hFFFF), .INIT_CYCLES(2)) dut_a (
        .CLK(CLK), .reset(reset), .bus(ifa));
    run_sequencer #(.CW(16), .MAX_CYCLES(5), .INIT_CYCLES(2)) dut_b (
        .CLK(CLK), .reset(reset), .bus(ifb));

    // {START, busy, host_done, timeout, cycles, alu_op, bnz, bz, babs, we, rsel, lut, m2r, src, sc, rd, wr}
    wire [33:0] obs_a = {ifa.START, ifa.busy, ifa.host_done, ifa.timeout, ifa.cycles,
        ifa.CTRL_alu_op, ifa.CTRL_branch_rel_nz, ifa.CTRL_branch_rel_z, ifa.CTRL_branch_abs,
        ifa.CTRL_reg_write_en, ifa.CTRL_reg_sel, ifa.CTRL_lut_in, ifa.CTRL_mem_to_reg,
        ifa.CTRL_alu_src, ifa.CTRL_alu_sc_in, ifa.CTRL_read_mem, ifa.CTRL_write_mem};
    wire [33:0] obs_b = {ifb.START, ifb.busy, ifb.host_done, ifb.timeout, ifb.cycles,
        ifb.CTRL_alu_op, ifb.CTRL_branch_rel_nz, ifb.CTRL_branch_rel_z, ifb.CTRL_branch_abs,
        ifb.CTRL_reg_write_en, ifb.CTRL_reg_sel, ifb.CTRL_lut_in, ifb.CTRL_mem_to_reg,
        ifb.CTRL_alu_src, ifb.CTRL_alu_sc_in, ifb.CTRL_read_mem, ifb.CTRL_write_mem};

    // hand-derived strobes for opcodes 0..F with fcode=1
    localparam logic [13:0] DEC1 [16] = '{
        14'b000_000_1000_0000, 14'b001_000_1000_0100, 14'b010_000_1000_0000, 14'b011_000_1000_0000,
        14'b100_000_1000_0000, 14'b101_000_1000_0100, 14'b110_000_1000_0100, 14'b000_000_1000_1000,
        14'b000_000_1001_0010, 14'b000_000_0000_0001, 14'b000_100_0000_0000, 14'b000_010_0000_0000,
        14'b000_001_0000_0000, 14'b000_001_0010_0000, 14'b000_000_1100_0000, 14'b111_000_0000_0000};
    localparam logic [13:0] ADD_C = 14'b000_000_1000_0000;

    typedef struct {
        int          cyc;
        int          d;
        string       nm;
        logic [33:0] v;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        exp_t        e;
        logic [33:0] a;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            a = (e.d == 0) ? obs_a : obs_b;
            checks++;
            if (e.cyc != cyc || a !== e.v) begin
                errors++;
                $display("FAIL %s dut%0d cyc %0d: got %h expected %h", e.nm, e.d, e.cyc, a, e.v);
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drv(int d, logic g, logic ab, logic [3:0] op, logic f, logic dn);
        go_v[d] = g; ab_v[d] = ab; op_v[d] = op; fc_v[d] = f; dn_v[d] = dn;
    endtask

    task automatic expv(int d, string nm, logic st, logic bs, logic hd, logic to,
                        logic [15:0] c, logic [13:0] ct);
        exp_t e;
        e.cyc = cyc; e.d = d; e.nm = nm; e.v = {st, bs, hd, to, c, ct};
        sb.push_back(e);
    endtask

    task automatic idle(int d, string nm, logic to, logic [15:0] c);  expv(d, nm, 1, 0, 0, to, c, '0); endtask
    task automatic init(int d, string nm);                            expv(d, nm, 1, 1, 0, 0, '0, '0); endtask
    task automatic run(int d, string nm, logic [15:0] c, logic [13:0] ct); expv(d, nm, 0, 1, 0, 0, c, ct); endtask
    task automatic drain(int d, string nm, logic to, logic [15:0] c); expv(d, nm, 0, 1, 0, to, c, '0); endtask
    task automatic fin(int d, string nm, logic to, logic [15:0] c);   expv(d, nm, 1, 0, 1, to, c, '0); endtask

    initial begin
        #20000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        drv(0, 0, 0, 4'h0, 1, 0);
        drv(1, 0, 0, 4'h0, 1, 0);
        step; reset = 1'b0;
        idle(0, "reset_a", 0, 0); idle(1, "reset_b", 0, 0);

        // run 1: init hold, then every opcode with fcode=1
        step; go_v[0] = 1'b1; idle(0, "go_sample", 0, 0);
        step; init(0, "init1");
        step; init(0, "init2");
        for (int i = 0; i < 16; i++) begin
            step; op_v[0] = 4'(i); run(0, "decode", 16'(i), DEC1[i]);
        end
        step; drv(0, 1, 0, 4'h5, 0, 0); run(0, "shl_f0", 16, 14'b101_000_1000_0000);
        step; drv(0, 1, 0, 4'h1, 0, 1); run(0, "sub_f0_done", 17, DEC1[1]);
        step; drv(0, 1, 0, 4'h8, 1, 0); drain(0, "drain_gated", 0, 18);
        step; fin(0, "finish", 0, 18);
        step; ab_v[0] = 1'b1; fin(0, "abort_in_finish", 0, 18);
        step; drv(0, 0, 0, 4'h0, 1, 0); fin(0, "finish_hold", 0, 18);
        step; idle(0, "idle_after_go_low", 0, 18);

        // run 2: DONE on the 10th RUN cycle
        go_v[0] = 1'b1;
        step; init(0, "r2_init1");
        step; init(0, "r2_init2");
        for (int i = 0; i < 10; i++) begin
            step; dn_v[0] = (i == 9); run(0, "r2_run", 16'(i), ADD_C);
        end
        step; dn_v[0] = 1'b0; drain(0, "r2_drain", 0, 10);
        step; go_v[0] = 1'b0; fin(0, "r2_done10", 0, 10);
        step; idle(0, "r2_idle", 0, 10);

        // run 3: abort on the third RUN cycle
        go_v[0] = 1'b1;
        step; init(0, "r3_init1");
        step; init(0, "r3_init2");
        step; run(0, "r3_run0", 0, ADD_C);
        step; run(0, "r3_run1", 1, ADD_C);
        step; drv(0, 0, 1, 4'hE, 1, 0); run(0, "r3_abort_cyc", 2, DEC1[14]);
        step; ab_v[0] = 1'b0; idle(0, "r3_aborted", 0, 3);
        step; idle(0, "r3_stays_idle", 0, 3);

        // dut 1: watchdog with DONE never raised
        step; go_v[1] = 1'b1; idle(1, "b_go", 0, 0);
        step; init(1, "b_init1");
        step; init(1, "b_init2");
        for (int i = 0; i < 5; i++) begin
            step; run(1, "b_run", 16'(i), ADD_C);
        end
        step; go_v[1] = 1'b0; fin(1, "b_timeout", 1, 5);
        step; go_v[1] = 1'b1; idle(1, "b_timeout_held", 1, 5);
        step; init(1, "b2_init_clears");
        step; init(1, "b2_init2");
        for (int i = 0; i < 5; i++) begin
            step; dn_v[1] = (i == 4); run(1, "b2_run", 16'(i), ADD_C);
        end
        step; dn_v[1] = 1'b0; drain(1, "b2_drain", 0, 5);
        step; go_v[1] = 1'b0; fin(1, "b2_done_wins", 0, 5);
        step; idle(1, "b2_idle", 0, 5);

        // async reset between edges while dut 0 is in RUN
        go_v[0] = 1'b1;
        step; init(0, "r4_init1");
        step; init(0, "r4_init2");
        step; op_v[0] = 4'h3; run(0, "r4_run0", 0, DEC1[3]);
        step; op_v[0] = 4'h8; run(0, "r4_run1", 1, DEC1[8]);
        step; idle(0, "async_reset_a", 0, 0); idle(1, "async_reset_b", 0, 0);
        #1 reset = 1'b1;
        step; reset = 1'b0; drv(0, 0, 0, 4'h0, 1, 0);
        idle(0, "post_reset_a", 0, 0); idle(1, "post_reset_b", 0, 0);
        step; step;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/run_sequencer.md
# run_sequencer

Top-level controller for the single-cycle 9-bit-instruction datapath. It performs a go/done handshake with a host and holds the datapath in init (`START`) until a run is requested. During the run it decodes `opcode`/`fcode` into every `CTRL_*` strobe and counts executed cycles. It enforces a watchdog limit and finishes cleanly when the datapath raises `DONE`.

## Interface
Parameters:
- `CW`, 16, width of cycle counter.
- `MAX_CYCLES`, 16'hFFFF, watchdog limit in RUN cycles (≥1).
- `INIT_CYCLES`, 2, cycles `START` is held after a go (≥1).

Ports:
- `CLK`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `go`  in  1  host run request, level.
- `abort`  in  1  host abort, level, sampled in INIT/RUN.
- `busy`  out  1  run in progress (INIT, RUN, DRAIN).
- `host_done`  out  1  run finished, held in FINISH.
- `timeout`  out  1  last run hit `MAX_CYCLES`, valid with `host_done`.
- `cycles`  out  CW  RUN cycles of current/last run.
- `opcode`  in  4  from datapath.
- `fcode`  in  1  from datapath.
- `DONE`  in  1  datapath program-complete.
- `START`  out  1  datapath init.
- `CTRL_branch_rel_nz`, `CTRL_branch_rel_z`, `CTRL_branch_abs`, `CTRL_reg_write_en`, `CTRL_reg_sel`, `CTRL_lut_in`, `CTRL_mem_to_reg`, `CTRL_alu_src`, `CTRL_alu_sc_in`, `CTRL_read_mem`, `CTRL_write_mem`  out  1 each  datapath strobes.
- `CTRL_alu_op`  out  3  ALU op.

## Operation
- FSM states: IDLE, INIT, RUN, DRAIN, FINISH.
- IDLE: `START`=1, strobes 0. If `go`=1, go to INIT, clear `cycles` and `timeout`.
- INIT: `START`=1 for `INIT_CYCLES` cycles (down-counter), then go to RUN.
- RUN: `START`=0. Strobes are combinational decode of `opcode`/`fcode`. `cycles` increments each RUN cycle and saturates at all-ones.
  - `DONE`=1: go to DRAIN.
  - Else, if `cycles`==`MAX_CYCLES`-1: set `timeout`, go to FINISH.
  - `DONE` and the limit in the same cycle: `DONE` wins, `timeout`=0.
- DRAIN: one cycle with all strobes 0, letting the final write commit. Then go to FINISH.
- FINISH: `host_done`=1, `START`=1. Stay until `go`=0, then go to IDLE. `cycles` and `timeout` hold until the next go.
- `abort`=1 in INIT or RUN: go to IDLE next edge with strobes 0. `abort` is ignored in other states.
- Strobes are forced to 0 in every state except RUN.
- Decode (ALU ops ADD0 SUB1 AND2 OR3 XOR4 SHL5 SHR6 PASS7). Unlisted strobes are 0:
  - 0x0–0x4: ADD/SUB/AND/OR/XOR; `reg_write_en`=1; `alu_sc_in`=1 for SUB only.
  - 0x5 SHL, 0x6 SHR: `reg_write_en`=1, `alu_sc_in`=`fcode`.
  - 0x7 ADDI: ADD, `alu_src`=1, `reg_write_en`=1.
  - 0x8 LD: `read_mem`, `mem_to_reg`, `reg_write_en`.
  - 0x9 ST: `write_mem`.
  - 0xA BNZ: `branch_rel_nz`. 0xB BZ: `branch_rel_z`.
  - 0xC JMP: `branch_abs`. 0xD JR: `branch_abs`, `lut_in`.
  - 0xE SETR: `reg_sel`, `reg_write_en`.
  - 0xF HALT: all 0, `alu_op`=PASS.

## Timing
- Reset values: state IDLE, `START`=1, `busy`=0, `host_done`=0, `timeout`=0, `cycles`=0, all strobes 0.
- The first RUN instruction executes `INIT_CYCLES`+1 edges after `go` is sampled.
- `host_done` asserts 2 edges after the RUN edge that sees `DONE`, or 1 edge after a timeout.
- `cycles` counts the RUN edge that sees `DONE`.
- Reset mid-run: immediate IDLE, `START`=1.

## Structure
- Package `definitions` holds:
  - `op_mne` (ALU op enum),
  - opcode enum `opc_e` (ADD…HALT),
  - `seq_state_e`.
- Sub-module `ctrl_decode` is combinational: opcode, fcode, enable → strobes.
- The FSM, counters and flag registers stay in `run_sequencer`.

## Test plan
- Reset, then `go`=1 with `INIT_CYCLES`=2: `START` high for 2 post-go cycles, `busy`=1, strobes 0 until RUN.
- Feed opcodes 0x0–0xF in RUN, `fcode`=1: each strobe vector matches the decode list. Examples: 0x6 gives `alu_op`=6, `sc_in`=1; 0x8 gives LD triple.
- `DONE` after 10 RUN cycles: DRAIN strobes 0, `host_done`=1, `cycles`=10, `timeout`=0. Drop `go`: IDLE next edge.
- `MAX_CYCLES`=5, `DONE` never: `host_done`=1, `timeout`=1, `cycles`=5. Variant with `DONE` on cycle 5: `timeout`=0.
- `abort` on 3rd RUN cycle: IDLE next edge, `START`=1, strobes 0. `abort` in FINISH has no effect.
- Async `reset` mid-RUN between edges: all outputs take reset values immediately.
